// File: rtl/branch_resolve_ctrl_if.sv
// Interface bundling the decode-side branch information, the PC redirect,
// the predictor table write port and the fetch-side bypass of
// branch_resolve_ctrl.
//   master : drives decode/fetch inputs, consumes redirect/update/bypass
//            (decode stage, testbench)
//   slave  : the resolution controller itself
interface branch_resolve_ctrl_if #(
  parameter int unsigned IDX_W  = 4,
  parameter int unsigned ADDR_W = 16
);
  // Decode-side inputs
  logic              stall;
  logic              ID_valid;
  logic              is_branch;
  logic              actual_taken;
  logic [ADDR_W-1:0] actual_target;
  logic [1:0]        IF_ID_prediction;
  logic [ADDR_W-1:0] IF_ID_predicted_target;
  logic [ADDR_W-1:0] IF_ID_PC_curr;
  logic [ADDR_W-1:0] IF_ID_PC_next;
  logic [IDX_W-1:0]  PC_curr_idx;

  // Redirect
  logic              update_PC;
  logic [ADDR_W-1:0] redirect_target;
  logic              flush_IF_ID;

  // Predictor table write port
  logic              wen_BHT;
  logic              wen_BTB;
  logic [IDX_W-1:0]  upd_idx;
  logic [1:0]        upd_counter;
  logic [ADDR_W-1:0] upd_target;

  // Fetch bypass
  logic              byp_hit;
  logic [1:0]        byp_prediction;
  logic [ADDR_W-1:0] byp_target;

  modport master (
    output stall, ID_valid, is_branch, actual_taken, actual_target,
           IF_ID_prediction, IF_ID_predicted_target, IF_ID_PC_curr, IF_ID_PC_next,
           PC_curr_idx,
    input  update_PC, redirect_target, flush_IF_ID,
           wen_BHT, wen_BTB, upd_idx, upd_counter, upd_target,
           byp_hit, byp_prediction, byp_target
  );

  modport slave (
    input  stall, ID_valid, is_branch, actual_taken, actual_target,
           IF_ID_prediction, IF_ID_predicted_target, IF_ID_PC_curr, IF_ID_PC_next,
           PC_curr_idx,
    output update_PC, redirect_target, flush_IF_ID,
           wen_BHT, wen_BTB, upd_idx, upd_counter, upd_target,
           byp_hit, byp_prediction, byp_target
  );
endinterface

// File: rtl/branch_resolve_ctrl.sv
// Decode-stage branch resolution controller for the 16-bit pipeline.
// Compares each resolved branch with the prediction carried in IF/ID, raises
// a PC redirect plus IF/ID flush on a mispredict, and writes the updated 2-bit
// BHT counter / BTB target into the predictor one cycle later. A fetch-side
// bypass forwards the in-flight update to a fetch that hits the same index.
//
// Ports:
//   clk  : clock
//   rst  : synchronous, active-high reset
//   bus  : branch_resolve_ctrl_if.slave (decode inputs, redirect, table
//          write port, bypass)
//   stat_branches / stat_mispredicts / stat_btb_writes / stat_stalls :
//          16-bit saturating statistics, present only when BRANCH_STATS_EN
//          is defined.
module branch_resolve_ctrl #(
  parameter int unsigned IDX_W  = 4,
  parameter int unsigned ADDR_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  branch_resolve_ctrl_if.slave  bus
`ifdef BRANCH_STATS_EN
  ,
  output logic [15:0]           stat_branches,
  output logic [15:0]           stat_mispredicts,
  output logic [15:0]           stat_btb_writes,
  output logic [15:0]           stat_stalls
`endif
);

  typedef enum logic [0:0] {StIdle, StSquash} state_e;

  state_e state_q, state_d;

  logic              resolve;
  logic              mispredicted;
  logic              target_miscomputed;
  logic              redir_taken;
  logic              redir_ft;
  logic              redirect;
  logic [1:0]        counter_next;

  logic              wen_bht_q;
  logic              wen_btb_q;
  logic [IDX_W-1:0]  upd_idx_q;
  logic [1:0]        upd_counter_q;
  logic [ADDR_W-1:0] upd_target_q;

  // Only the low PC bits index the tables.
  logic unused_pc_hi;
  assign unused_pc_hi = ^bus.IF_ID_PC_curr[ADDR_W-1:IDX_W];

  // Resolution and redirect decision. Gating with rst drops a redirect that
  // coincides with reset.
  always_comb begin
    resolve            = bus.ID_valid & bus.is_branch & ~bus.stall &
                         (state_q == StIdle) & ~rst;
    mispredicted       = bus.IF_ID_prediction[1] != bus.actual_taken;
    target_miscomputed = bus.IF_ID_predicted_target != bus.actual_target;
    redir_taken        = resolve & bus.actual_taken & (mispredicted | target_miscomputed);
    redir_ft           = resolve & ~bus.actual_taken & bus.IF_ID_prediction[1];
    redirect           = redir_taken | redir_ft;

    // Saturating 2-bit counter step
    counter_next = bus.IF_ID_prediction;
    if (bus.actual_taken) begin
      if (bus.IF_ID_prediction != 2'b11) counter_next = bus.IF_ID_prediction + 2'b01;
    end else begin
      if (bus.IF_ID_prediction != 2'b00) counter_next = bus.IF_ID_prediction - 2'b01;
    end
  end

  always_comb begin
    bus.update_PC       = redirect;
    bus.flush_IF_ID     = redirect;
    bus.redirect_target = '0;
    if (redir_taken) begin
      bus.redirect_target = bus.actual_target;
    end else if (redir_ft) begin
      bus.redirect_target = bus.IF_ID_PC_next;
    end
  end

  // After a redirect the instruction now in ID is wrong-path; hold off
  // resolution until the pipeline has advanced past it.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (redirect) state_d = StSquash;
      StSquash: if (!bus.stall) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Update stage: not held by stall, so each strobe is a single-cycle pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      wen_bht_q     <= 1'b0;
      wen_btb_q     <= 1'b0;
      upd_idx_q     <= '0;
      upd_counter_q <= 2'b00;
      upd_target_q  <= '0;
    end else begin
      state_q   <= state_d;
      wen_bht_q <= resolve & (counter_next != bus.IF_ID_prediction);
      wen_btb_q <= resolve & bus.actual_taken & target_miscomputed;
      if (resolve) begin
        upd_idx_q     <= bus.IF_ID_PC_curr[IDX_W-1:0];
        upd_counter_q <= counter_next;
        upd_target_q  <= bus.actual_target;
      end
    end
  end

  assign bus.wen_BHT     = wen_bht_q;
  assign bus.wen_BTB     = wen_btb_q;
  assign bus.upd_idx     = upd_idx_q;
  assign bus.upd_counter = upd_counter_q;
  assign bus.upd_target  = upd_target_q;

  // Bypass: fields are zeroed unless their own strobe is live.
  assign bus.byp_hit        = (wen_bht_q | wen_btb_q) & (bus.PC_curr_idx == upd_idx_q);
  assign bus.byp_prediction = wen_bht_q ? upd_counter_q : 2'b00;
  assign bus.byp_target     = wen_btb_q ? upd_target_q : '0;

`ifdef BRANCH_STATS_EN
  logic [15:0] stat_branches_q, stat_mispredicts_q, stat_btb_writes_q, stat_stalls_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_branches_q    <= '0;
      stat_mispredicts_q <= '0;
      stat_btb_writes_q  <= '0;
      stat_stalls_q      <= '0;
    end else begin
      if (resolve && stat_branches_q != 16'hFFFF) stat_branches_q <= stat_branches_q + 16'd1;
      if (redirect && stat_mispredicts_q != 16'hFFFF) begin
        stat_mispredicts_q <= stat_mispredicts_q + 16'd1;
      end
      if (wen_btb_q && stat_btb_writes_q != 16'hFFFF) begin
        stat_btb_writes_q <= stat_btb_writes_q + 16'd1;
      end
      if (bus.stall && stat_stalls_q != 16'hFFFF) stat_stalls_q <= stat_stalls_q + 16'd1;
    end
  end

  assign stat_branches    = stat_branches_q;
  assign stat_mispredicts = stat_mispredicts_q;
  assign stat_btb_writes  = stat_btb_writes_q;
  assign stat_stalls      = stat_stalls_q;
`endif

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Directed bench for branch_resolve_ctrl: a table of single-branch vectors
// plus hand-written sequences for squash, stall, bypass and reset.
module tb_branch_resolve_ctrl;

  logic clk;
  logic rst;

  branch_resolve_ctrl_if #(.IDX_W(4), .ADDR_W(16)) bus ();

`ifdef BRANCH_STATS_EN
  logic [15:0] stat_branches, stat_mispredicts, stat_btb_writes, stat_stalls;
`endif

  branch_resolve_ctrl #(.IDX_W(4), .ADDR_W(16)) dut (
    .clk              (clk),
    .rst              (rst),
    .bus              (bus.slave)
`ifdef BRANCH_STATS_EN
    ,
    .stat_branches    (stat_branches),
    .stat_mispredicts (stat_mispredicts),
    .stat_btb_writes  (stat_btb_writes),
    .stat_stalls      (stat_stalls)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    else n_pass++;
  endtask

  typedef struct {
    logic        id_valid;
    logic        is_branch;
    logic        stall;
    logic [1:0]  pred;
    logic        taken;
    logic [15:0] act_tgt;
    logic [15:0] pred_tgt;
    logic [15:0] pc_curr;
    logic [15:0] pc_next;
    logic        exp_upd;
    logic [15:0] exp_rt;
    logic        exp_res;
    logic        exp_bht;
    logic        exp_btb;
    logic [3:0]  exp_idx;
    logic [1:0]  exp_cnt;
    logic [15:0] exp_tgt;
  } vec_t;

  localparam int NVec = 11;
  vec_t vecs[NVec];

  task automatic drive_branch(input logic v, input logic b, input logic s, input logic [1:0] p,
                              input logic t, input logic [15:0] at, input logic [15:0] pt,
                              input logic [15:0] pc, input logic [15:0] pn);
    bus.ID_valid               = v;
    bus.is_branch              = b;
    bus.stall                  = s;
    bus.IF_ID_prediction       = p;
    bus.actual_taken           = t;
    bus.actual_target          = at;
    bus.IF_ID_predicted_target = pt;
    bus.IF_ID_PC_curr          = pc;
    bus.IF_ID_PC_next          = pn;
  endtask

  task automatic bubble();
    drive_branch(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 16'h0, 16'h0, 16'h0, 16'h0);
  endtask

  initial begin
    // Vectors: valid, branch, stall, pred, taken, act_tgt, pred_tgt, pc, pc_next |
    //          upd_PC, redirect_target, resolves, wen_BHT, wen_BTB, idx, counter, target
    vecs[0]  = '{1, 1, 0, 2'b10, 1, 16'h0040, 16'h0040, 16'h0006, 16'h0008,
                 0, 16'h0000, 1, 1, 0, 4'h6, 2'b11, 16'h0040};
    vecs[1]  = '{1, 1, 0, 2'b01, 1, 16'h0120, 16'h0000, 16'h0002, 16'h0004,
                 1, 16'h0120, 1, 1, 1, 4'h2, 2'b10, 16'h0120};
    vecs[2]  = '{1, 1, 0, 2'b11, 0, 16'h0050, 16'h0050, 16'h0008, 16'h000A,
                 1, 16'h000A, 1, 1, 0, 4'h8, 2'b10, 16'h0050};
    vecs[3]  = '{1, 1, 0, 2'b11, 1, 16'h0200, 16'h0100, 16'h000C, 16'h000E,
                 1, 16'h0200, 1, 0, 1, 4'hC, 2'b11, 16'h0200};
    vecs[4]  = '{1, 1, 0, 2'b00, 0, 16'h0030, 16'h0030, 16'h0010, 16'h0012,
                 0, 16'h0000, 1, 0, 0, 4'h0, 2'b00, 16'h0030};
    vecs[5]  = '{1, 1, 0, 2'b01, 0, 16'h0060, 16'h0070, 16'h001E, 16'h0020,
                 0, 16'h0000, 1, 1, 0, 4'hE, 2'b00, 16'h0060};
    vecs[6]  = '{1, 1, 0, 2'b10, 0, 16'h0080, 16'h0080, 16'h0020, 16'h0022,
                 1, 16'h0022, 1, 1, 0, 4'h0, 2'b01, 16'h0080};
    vecs[7]  = '{1, 0, 0, 2'b01, 1, 16'h0120, 16'h0000, 16'h0024, 16'h0026,
                 0, 16'h0000, 0, 0, 0, 4'h0, 2'b00, 16'h0000};
    vecs[8]  = '{0, 1, 0, 2'b01, 1, 16'h0120, 16'h0000, 16'h0024, 16'h0026,
                 0, 16'h0000, 0, 0, 0, 4'h0, 2'b00, 16'h0000};
    vecs[9]  = '{1, 1, 1, 2'b01, 1, 16'h0120, 16'h0000, 16'h0024, 16'h0026,
                 0, 16'h0000, 0, 0, 0, 4'h0, 2'b00, 16'h0000};
    vecs[10] = '{1, 1, 0, 2'b01, 1, 16'h0090, 16'h0090, 16'h0013, 16'h0015,
                 1, 16'h0090, 1, 1, 0, 4'h3, 2'b10, 16'h0090};

    rst = 1'b1;
    bubble();
    bus.PC_curr_idx = 4'h0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_update_PC", bus.update_PC, 0);
    check("rst_flush", bus.flush_IF_ID, 0);
    check("rst_wen_BHT", bus.wen_BHT, 0);
    check("rst_wen_BTB", bus.wen_BTB, 0);
    check("rst_upd_target", bus.upd_target, 0);
    @(negedge clk);
    rst = 1'b0;

    // Table-driven single branches, each followed by a bubble
    for (int i = 0; i < NVec; i++) begin
      drive_branch(vecs[i].id_valid, vecs[i].is_branch, vecs[i].stall, vecs[i].pred,
                   vecs[i].taken, vecs[i].act_tgt, vecs[i].pred_tgt, vecs[i].pc_curr,
                   vecs[i].pc_next);
      #1;
      check($sformatf("v%0d_update_PC", i), bus.update_PC, vecs[i].exp_upd);
      check($sformatf("v%0d_flush", i), bus.flush_IF_ID, vecs[i].exp_upd);
      check($sformatf("v%0d_redirect_target", i), bus.redirect_target, vecs[i].exp_rt);
      @(posedge clk);
      #1;
      check($sformatf("v%0d_wen_BHT", i), bus.wen_BHT, vecs[i].exp_bht);
      check($sformatf("v%0d_wen_BTB", i), bus.wen_BTB, vecs[i].exp_btb);
      if (vecs[i].exp_res) begin
        check($sformatf("v%0d_upd_idx", i), bus.upd_idx, vecs[i].exp_idx);
        check($sformatf("v%0d_upd_counter", i), bus.upd_counter, vecs[i].exp_cnt);
        check($sformatf("v%0d_upd_target", i), bus.upd_target, vecs[i].exp_tgt);
      end
      @(negedge clk);
      bubble();
      @(posedge clk);
      #1;
      check($sformatf("v%0d_strobe_end", i), {bus.wen_BHT, bus.wen_BTB}, 0);
      @(negedge clk);
    end

    // Branch right after a redirect is wrong-path and must be ignored
    drive_branch(1, 1, 0, 2'b11, 0, 16'h0050, 16'h0050, 16'h0008, 16'h000A);
    #1;
    check("sq_first_redirect", bus.redirect_target, 16'h000A);
    @(negedge clk);
    drive_branch(1, 1, 0, 2'b00, 1, 16'h0500, 16'h0000, 16'h0030, 16'h0032);
    #1;
    check("sq_ignored_update_PC", bus.update_PC, 0);
    @(posedge clk);
    #1;
    check("sq_ignored_strobes", {bus.wen_BHT, bus.wen_BTB}, 0);
    @(negedge clk);
    #1;
    check("sq_after_resolves", bus.update_PC, 1);
    check("sq_after_target", bus.redirect_target, 16'h0500);
    @(negedge clk);
    bubble();
    @(negedge clk);

    // Stall held over a mispredicted branch for three cycles
    drive_branch(1, 1, 1, 2'b00, 1, 16'h0300, 16'h0000, 16'h0014, 16'h0016);
    for (int c = 0; c < 3; c++) begin
      #1;
      check($sformatf("stall%0d_update_PC", c), bus.update_PC, 0);
      @(posedge clk);
      #1;
      check($sformatf("stall%0d_strobes", c), {bus.wen_BHT, bus.wen_BTB}, 0);
      @(negedge clk);
    end
    bus.stall = 1'b0;
    #1;
    check("stall_rel_update_PC", bus.update_PC, 1);
    check("stall_rel_target", bus.redirect_target, 16'h0300);
    @(posedge clk);
    #1;
    check("stall_rel_strobes", {bus.wen_BHT, bus.wen_BTB}, 2'b11);
    check("stall_rel_counter", bus.upd_counter, 2'b01);
    check("stall_rel_idx", bus.upd_idx, 4'h4);
    @(negedge clk);
    #1;
    check("stall_once_update_PC", bus.update_PC, 0);
    @(posedge clk);
    #1;
    check("stall_once_strobes", {bus.wen_BHT, bus.wen_BTB}, 0);
    @(negedge clk);
    bubble();
    @(negedge clk);

    // Bypass of a BTB-only update, then a BHT-only update
    drive_branch(1, 1, 0, 2'b11, 1, 16'h0444, 16'h0010, 16'h0004, 16'h0006);
    bus.PC_curr_idx = 4'h4;
    @(posedge clk);
    #1;
    check("byp_btb_hit", bus.byp_hit, 1);
    check("byp_btb_target", bus.byp_target, 16'h0444);
    check("byp_btb_prediction", bus.byp_prediction, 2'b00);
    bus.PC_curr_idx = 4'h5;
    #1;
    check("byp_other_idx", bus.byp_hit, 0);
    @(negedge clk);
    bubble();
    bus.PC_curr_idx = 4'h4;
    @(posedge clk);
    #1;
    check("byp_expired", bus.byp_hit, 0);
    @(negedge clk);
    drive_branch(1, 1, 0, 2'b01, 1, 16'h0090, 16'h0090, 16'h0007, 16'h0009);
    bus.PC_curr_idx = 4'h7;
    @(posedge clk);
    #1;
    check("byp_bht_hit", bus.byp_hit, 1);
    check("byp_bht_prediction", bus.byp_prediction, 2'b10);
    check("byp_bht_target", bus.byp_target, 16'h0000);
    @(negedge clk);
    bubble();
    @(negedge clk);

    // Reset coinciding with a redirect
    drive_branch(1, 1, 0, 2'b10, 1, 16'h0040, 16'h0040, 16'h000F, 16'h0011);
    @(negedge clk);
    drive_branch(1, 1, 0, 2'b00, 1, 16'h0700, 16'h0000, 16'h0005, 16'h0007);
    bus.PC_curr_idx = 4'h5;
    rst = 1'b1;
    #1;
    check("rstmid_update_PC", bus.update_PC, 0);
    check("rstmid_flush", bus.flush_IF_ID, 0);
    @(posedge clk);
    #1;
    check("rstmid_strobes", {bus.wen_BHT, bus.wen_BTB}, 0);
    check("rstmid_upd_idx", bus.upd_idx, 0);
    check("rstmid_upd_counter", bus.upd_counter, 0);
    check("rstmid_upd_target", bus.upd_target, 0);
    check("rstmid_byp", {bus.byp_hit, bus.byp_prediction, bus.byp_target}, 0);
    check("rstmid_redirect_target", bus.redirect_target, 0);
`ifdef BRANCH_STATS_EN
    check("rstmid_stats", {stat_branches, stat_mispredicts}, 0);
    check("rstmid_stats2", {stat_btb_writes, stat_stalls}, 0);
`endif
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rstmid_idle_resolves", bus.update_PC, 1);
    check("rstmid_idle_target", bus.redirect_target, 16'h0700);
    @(negedge clk);
    bubble();
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Absolute time bound so the bench always terminates
  initial begin
    #200000;
    $display("FAIL timeout: got no finish, required finish");
    $fatal(1);
  end

endmodule
